aes_cbc_ctrl: RTL
=================

Name: aes_cbc_ctrl

Overview:
Chaining and flow-control front end for the iterative AES-128 core (aes_core).
- Accepts plaintext blocks on a valid/ready stream and buffers them in a small FIFO.
- In CBC mode, XORs each block with the chaining value, launches the core, and captures the ciphertext when the core finishes.
- Presents each ciphertext on a valid/ready output stream and updates the chaining value.
- Sits between the bus/DMA interface and aes_core, and owns the core's start/ready handshake.

Parameters:
- FIFO_DEPTH, 4, input block FIFO entries; power of 2, minimum 2.
- ROUNDS, 10, value driven on core_rounds (4 bits).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- key_in, input, 128, cipher key; sampled at each launch.
- iv_load, input, 1, load iv into the chaining register.
- iv, input, 128, initialisation vector.
- in_valid, input, 1, plaintext block valid.
- in_data, input, 128, plaintext block.
- in_ready, output, 1, FIFO can accept a block.
- out_valid, output, 1, ciphertext valid.
- out_data, output, 128, ciphertext block.
- out_ready, input, 1, downstream accepts the block.
- core_start, output, 1, one-cycle launch pulse to aes_core.
- core_plaintext, output, 128, block to the core (already chained).
- core_key, output, 128, key to the core.
- core_rounds, output, 4, round count to the core.
- core_ciphertext, input, 128, core result.
- core_ready, input, 1, core idle/done; high out of reset.
- busy, output, 1, FSM not IDLE or FIFO non-empty.
- blk_count, output, 16, completed output handshakes.

Behaviour:
- Reset (async): FSM=IDLE; FIFO empty; chain=0; core_start=0; core_plaintext=0; core_key=0; out_valid=0; out_data=0; blk_count=0; busy=0.
  - in_ready=1 once FIFO is empty.
  - core_rounds=ROUNDS at all times.
- Reset mid-operation aborts everything:
  - FIFO contents, the chaining value, and any pending output are discarded.
  - The core is not re-launched.
- FIFO:
  - in_ready = !full, combinational from the occupancy count.
  - Push when in_valid && in_ready.
  - Pop only in the LAUNCH transition.
  - Push and pop in the same cycle leaves the count unchanged.
  - When full, in_ready=0 even if a pop occurs that cycle; no bypass.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, OUTPUT.
  - IDLE: if FIFO non-empty && core_ready, go to LAUNCH. Registered on that edge:
    - core_plaintext <= head ^ chain
    - core_key <= key_in
    - pop head
  - LAUNCH: core_start=1 for exactly this one cycle; go to WAIT_ACK.
  - WAIT_ACK: stay until core_ready==0, then go to WAIT_DONE. Guards against the stale ready level from before the launch.
  - WAIT_DONE: stay until core_ready==1. On that edge:
    - out_data <= core_ciphertext
    - out_valid <= 1
    - chain <= core_ciphertext
    - go to OUTPUT
  - OUTPUT: hold out_valid and out_data stable until out_ready. On the handshake edge:
    - out_valid <= 0
    - blk_count++ (wraps FFFF->0000)
    - go to IDLE
- Launch latency: first FIFO entry to core_start is 2 cycles (IDLE decision edge, LAUNCH cycle).
- core_plaintext and core_key are held constant from LAUNCH until the next launch.
- iv_load:
  - Honoured only in IDLE with an empty FIFO: chain <= iv on the next edge.
  - Ignored otherwise; no side effects.
  - If iv_load coincides with an IDLE->LAUNCH decision, it is ignored (FIFO is non-empty).
- busy = (state != IDLE) || FIFO non-empty.

Optional Feature:
AES_CBC_EN
- Defined: CBC behaviour exactly as above.
- Undefined (ECB):
  - chain is forced to 0 and never updated.
  - iv_load and iv are ignored.
  - core_plaintext = FIFO head.
  - All other timing is identical.

Test Plan:
Bench uses a core model: core_ready drops the cycle after core_start, rises 11 cycles later, and returns ciphertext = plaintext ^ key.
- Reset, then iv_load with iv=0, key_in=0, one block 128'h1 -> out_data=128'h1 after 14 cycles; blk_count=1.
- CBC chaining: iv=128'hFF, key=128'h0F, blocks A=128'h10 and B=128'h20 ->
  - core_plaintext A'=128'hEF, out=128'hE0
  - core_plaintext B'=128'hC0, out=128'hCF
- Backpressure: out_ready=0 for 30 cycles with 5 blocks pushed -> out_valid and out_data stable; in_ready=0 after 4 buffered blocks (FIFO_DEPTH=4); no launch while in OUTPUT.
- Simultaneous push and pop at count 3 -> count stays 3. Push attempt when full and popping -> rejected (in_ready=0).
- Assert rst_n low during WAIT_DONE -> all outputs return to reset values; a later block uses chain=0.
- ECB build (AES_CBC_EN undefined): two identical blocks 128'h55 with key 128'hAA -> both out_data=128'hFF; iv_load has no effect.

Source files
------------

// File: rtl/aes_cbc_ctrl_if.sv
// Stream and core-handshake bundle for aes_cbc_ctrl.
// slave: the controller's view. master: the surrounding bus/DMA and aes_core view.
interface aes_cbc_ctrl_if;
  // Plaintext input stream
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  // Ciphertext output stream
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready;
  // aes_core launch/result handshake
  logic         core_start;
  logic [127:0] core_plaintext;
  logic [127:0] core_key;
  logic [3:0]   core_rounds;
  logic [127:0] core_ciphertext;
  logic         core_ready;

  modport slave (
    input  in_valid, in_data, out_ready, core_ciphertext, core_ready,
    output in_ready, out_valid, out_data, core_start, core_plaintext, core_key, core_rounds
  );

  modport master (
    output in_valid, in_data, out_ready, core_ciphertext, core_ready,
    input  in_ready, out_valid, out_data, core_start, core_plaintext, core_key, core_rounds
  );
endinterface

// File: rtl/aes_cbc_ctrl.sv
// Chaining and flow-control front end for the iterative AES-128 core.
// Buffers plaintext in a small FIFO, chains each block with the previous ciphertext,
// launches aes_core, and streams the results out.
// Build option: define AES_CBC_EN for CBC chaining; left undefined the block runs ECB
// (chain held at zero, iv_load_i/iv_i ignored, identical timing).
module aes_cbc_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ROUNDS     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_cbc_ctrl_if.slave        bus,
  input  logic [127:0]         key_in_i,
  input  logic                 iv_load_i,
  input  logic [127:0]         iv_i,
  output logic                 busy_o,
  output logic [15:0]          blk_count_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitAck,
    StWaitDone,
    StOutput
  } state_e;

  state_e state_q, state_d;

  logic [127:0]    mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [127:0] core_pt_q, core_pt_d;
  logic [127:0] core_key_q, core_key_d;
  logic [127:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic [15:0]  blk_count_q, blk_count_d;

  logic [127:0] chain;
  logic [127:0] head;
  logic         fifo_empty;
  logic         push;
  logic         pop;

  assign fifo_empty   = (count_q == '0);
  // No bypass: a full FIFO refuses input even in the cycle it pops.
  assign bus.in_ready = (count_q != CntFull);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state_q == StIdle) && !fifo_empty && bus.core_ready;
  assign head         = mem_q[rd_ptr_q];

`ifdef AES_CBC_EN
  logic [127:0] chain_q, chain_d;

  // Chain takes the IV only when nothing is queued or in flight, else the last ciphertext.
  always_comb begin
    chain_d = chain_q;
    if ((state_q == StIdle) && fifo_empty && iv_load_i) begin
      chain_d = iv_i;
    end else if ((state_q == StWaitDone) && bus.core_ready) begin
      chain_d = bus.core_ciphertext;
    end
  end

  // Chaining register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign chain = chain_q;
`else
  logic unused_iv;

  assign unused_iv = iv_load_i ^ (^iv_i);
  assign chain     = '0;
`endif

  // FIFO storage; contents are don't-care until written, pointers carry the state.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // Next-state: FIFO bookkeeping and the launch/wait/output sequence.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    core_pt_d   = core_pt_q;
    core_key_d  = core_key_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    blk_count_d = blk_count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          core_pt_d  = head ^ chain;
          core_key_d = key_in_i;
          state_d    = StLaunch;
        end
      end
      StLaunch: begin
        state_d = StWaitAck;
      end
      // Ready may still be high from before the launch; wait for the core to take it.
      StWaitAck: begin
        if (!bus.core_ready) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (bus.core_ready) begin
          out_data_d  = bus.core_ciphertext;
          out_valid_d = 1'b1;
          state_d     = StOutput;
        end
      end
      StOutput: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          blk_count_d = blk_count_q + 16'd1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset abandons queued and in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      core_pt_q   <= '0;
      core_key_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      blk_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      core_pt_q   <= core_pt_d;
      core_key_q  <= core_key_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      blk_count_q <= blk_count_d;
    end
  end

  assign bus.core_start     = (state_q == StLaunch);
  assign bus.core_plaintext = core_pt_q;
  assign bus.core_key       = core_key_q;
  assign bus.core_rounds    = 4'(ROUNDS);
  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign busy_o             = (state_q != StIdle) || !fifo_empty;
  assign blk_count_o        = blk_count_q;

endmodule
